tdm_receiver: RTL and testbench
===============================

TDM_RECEIVER -- requirements
Module: tdm_receiver

Interface
REQ-001 SHALL have parameter SEG0_LEN, 88, byte count of segment 0 (channel 0).
REQ-002 SHALL have parameter SEG1_LEN, 80, byte count of segment 1 (channel 1).
REQ-003 SHALL have parameter SEG2_LEN, 56, byte count of segment 2 (channel 2).
REQ-004 SHALL have parameter SEG3_LEN, 32, byte count of segment 3 (channel 3).
REQ-005 SHALL have port sysclk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port holder  in  1  link enable; low forces synchronous clear to IDLE.
REQ-008 SHALL have port bit_valid  in  1  qualifies sdin and frame_sync this cycle.
REQ-009 SHALL have port sdin  in  1  serial data bit, MSB of each byte first.
REQ-010 SHALL have port frame_sync  in  1  marks first bit of a frame (sampled only with bit_valid).
REQ-011 SHALL have port ch_en  in  4  per-channel write enable; bit n gates channel n.
REQ-012 SHALL have port wr_en  out  4  one-hot write strobe to channel n buffer.
REQ-013 SHALL have port wr_addr  out  7  byte index within current segment.
REQ-014 SHALL have port wr_data  out  8  assembled byte.
REQ-015 SHALL have port seg  out  2  segment currently being received.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse after last byte of segment 3.
REQ-017 SHALL have port frame_err  out  1  one-cycle pulse on frame_sync arriving mid-frame.

Function
REQ-018 SHALL implement states IDLE and RECV.
REQ-019 IDLE -> RECV SHALL occur when holder & bit_valid & frame_sync; that bit SHALL be bit 7 of byte 0, segment 0.
REQ-020 In RECV, each bit_valid cycle SHALL shift sdin into an 8-bit register and advance a 3-bit bit counter; cycles with bit_valid low SHALL hold all state.
REQ-021 On the 8th valid bit, wr_data SHALL present the byte, wr_addr the byte counter, and wr_en[seg] SHALL pulse only if ch_en[seg]; outputs registered, valid the cycle after that bit's edge.
REQ-022 wr_en SHALL be 0 all other cycles; wr_data/wr_addr hold last values.
REQ-023 Byte counter SHALL wrap to 0 and seg SHALL increment after byte SEGn_LEN-1.
REQ-024 After byte SEG3_LEN-1 of segment 3, frame_done SHALL pulse together with the final wr_en and FSM SHALL return to IDLE (seg=0).
REQ-025 frame_sync with bit_valid in RECV SHALL pulse frame_err, discard the partial byte/frame, and restart at bit 7, byte 0, segment 0 using that bit.
REQ-026 frame_sync without bit_valid SHALL be ignored; frame_sync in IDLE without holder SHALL be ignored.
REQ-027 holder low SHALL, next edge, force IDLE, clear counters and shift register, and drive wr_en, frame_done, frame_err to 0.
REQ-028 Concurrent frame_done and frame_sync-restart SHALL not both fire: frame boundary frame_sync SHALL only arrive in IDLE.

Reset
REQ-029 reset SHALL asynchronously set state IDLE, counters 0, seg 0, wr_en 0, wr_addr 0, wr_data 0, frame_done 0, frame_err 0.
REQ-030 Reset mid-frame SHALL discard the frame; no write strobe SHALL follow deassertion until a new frame_sync.

Structure
REQ-031 Package tdm_pkg SHALL hold segment-length constants, the frame total (256 bytes), and the state enum, shared with the transmit-side splitter.
REQ-032 The bit-to-byte shifter SHALL be one sub-module, shift_in8 (shift register, bit counter, byte_ready pulse).

Verification
REQ-033 Full frame, bit_valid always 1, ch_en=4'hF, byte k = k[7:0] -> 256 writes; seg0 addr 0..87, seg3 addr 0..31 data 0xE0..0xFF; frame_done once.
REQ-034 ch_en=4'b0101 -> wr_en only for segments 0 and 2; counters still advance; frame_done pulses.
REQ-035 bit_valid toggled 1/0 each cycle -> identical write sequence to REQ-033 at half rate.
REQ-036 frame_sync injected at seg1 byte 10 bit 3 -> frame_err pulse, next write is seg0 addr 0.
REQ-037 holder low for 1 cycle mid-seg2 -> IDLE, no writes until next frame_sync; reset asserted mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM frame layout: segment lengths, frame size and receiver state encoding.
// Also used by the transmit-side splitter, so both ends agree on the framing.
package tdm_pkg;

    localparam int TDM_SEG0_LEN    = 88;
    localparam int TDM_SEG1_LEN    = 80;
    localparam int TDM_SEG2_LEN    = 56;
    localparam int TDM_SEG3_LEN    = 32;
    localparam int TDM_FRAME_BYTES = TDM_SEG0_LEN + TDM_SEG1_LEN + TDM_SEG2_LEN + TDM_SEG3_LEN;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/tdm_receiver_shift_in8.sv
// MSB-first serial-to-byte shifter. A start loads the first bit of a fresh byte,
// so a frame_sync bit can both abort the old byte and begin the new one.
module shift_in8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       start_i,
    input  logic       shift_i,
    input  logic       din_i,
    output logic [7:0] byte_o,
    output logic       byte_ready_o
);

    logic [6:0] sh_q, sh_d;
    logic [2:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (start_i) begin
            sh_d  = {6'b0, din_i};
            cnt_d = 3'd1;
        end else if (shift_i) begin
            sh_d  = {sh_q[5:0], din_i};
            cnt_d = cnt_q + 3'd1;
        end
    end

    // Only seven bits are stored; the eighth comes straight from din_i.
    assign byte_o       = {sh_q, din_i};
    assign byte_ready_o = shift_i && !clr_i && !start_i && (cnt_q == 3'd7);

endmodule

// File: rtl/tdm_receiver.sv
// TDM frame receiver: deserialises a 4-segment frame and emits per-channel
// byte writes with segment-relative addresses.
module tdm_receiver
    import tdm_pkg::*;
#(
    parameter int SEG0_LEN = TDM_SEG0_LEN,
    parameter int SEG1_LEN = TDM_SEG1_LEN,
    parameter int SEG2_LEN = TDM_SEG2_LEN,
    parameter int SEG3_LEN = TDM_SEG3_LEN
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       holder,
    input  logic       bit_valid,
    input  logic       sdin,
    input  logic       frame_sync,
    input  logic [3:0] ch_en,
    output logic [3:0] wr_en,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [1:0] seg,
    output logic       frame_done,
    output logic       frame_err
);

    localparam logic [6:0] LAST0 = 7'(SEG0_LEN - 1);
    localparam logic [6:0] LAST1 = 7'(SEG1_LEN - 1);
    localparam logic [6:0] LAST2 = 7'(SEG2_LEN - 1);
    localparam logic [6:0] LAST3 = 7'(SEG3_LEN - 1);

    function automatic logic [6:0] seg_last(input logic [1:0] s);
        case (s)
            2'd0:    return LAST0;
            2'd1:    return LAST1;
            2'd2:    return LAST2;
            default: return LAST3;
        endcase
    endfunction

    rx_state_t  state_q, state_d;
    logic [6:0] byte_cnt_q, byte_cnt_d;
    logic [1:0] seg_q, seg_d;
    logic [3:0] wr_en_q, wr_en_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       frame_done_q, frame_done_d;
    logic       frame_err_q, frame_err_d;

    logic       sh_clr, sh_start, sh_shift;
    logic [7:0] sh_byte;
    logic       sh_ready;

    shift_in8 u_shift (
        .clk          (sysclk),
        .rst          (reset),
        .clr_i        (sh_clr),
        .start_i      (sh_start),
        .shift_i      (sh_shift),
        .din_i        (sdin),
        .byte_o       (sh_byte),
        .byte_ready_o (sh_ready)
    );

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            seg_q        <= '0;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            seg_q        <= seg_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        seg_d        = seg_q;
        wr_en_d      = '0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        sh_clr       = 1'b0;
        sh_start     = 1'b0;
        sh_shift     = 1'b0;

        if (!holder) begin
            state_d    = ST_IDLE;
            byte_cnt_d = '0;
            seg_d      = '0;
            sh_clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bit_valid && frame_sync) begin
                        state_d    = ST_RECV;
                        byte_cnt_d = '0;
                        seg_d      = '0;
                        sh_start   = 1'b1;
                    end
                end
                default: begin
                    if (bit_valid && frame_sync) begin
                        // Mid-frame sync: abandon the frame, the sync bit opens a new one.
                        frame_err_d = 1'b1;
                        byte_cnt_d  = '0;
                        seg_d       = '0;
                        sh_start    = 1'b1;
                    end else if (bit_valid) begin
                        sh_shift = 1'b1;
                        if (sh_ready) begin
                            wr_data_d = sh_byte;
                            wr_addr_d = byte_cnt_q;
                            wr_en_d   = ch_en[seg_q] ? (4'b0001 << seg_q) : 4'b0000;
                            if (byte_cnt_q == seg_last(seg_q)) begin
                                byte_cnt_d = '0;
                                if (seg_q == 2'd3) begin
                                    frame_done_d = 1'b1;
                                    state_d      = ST_IDLE;
                                    seg_d        = '0;
                                end else begin
                                    seg_d = seg_q + 2'd1;
                                end
                            end else begin
                                byte_cnt_d = byte_cnt_q + 7'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_tdm_receiver.sv
// Scoreboard bench for tdm_receiver: expected writes are queued as bytes are
// serialised and matched against the write strobes the receiver produces.
module tb_tdm_receiver;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       holder;
    logic       bit_valid;
    logic       sdin;
    logic       frame_sync;
    logic [3:0] ch_en;
    logic [3:0] wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] seg;
    logic       frame_done;
    logic       frame_err;

    tdm_receiver dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .holder     (holder),
        .bit_valid  (bit_valid),
        .sdin       (sdin),
        .frame_sync (frame_sync),
        .ch_en      (ch_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .seg        (seg),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 sysclk = ~sysclk;

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_cnt       = 0;
    int done_cnt     = 0;
    int err_cnt      = 0;
    logic [18:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int seg_of(input int k);
        if (k < 88)  return 0;
        if (k < 168) return 1;
        if (k < 224) return 2;
        return 3;
    endfunction

    function automatic int base_of(input int s);
        case (s)
            0:       return 0;
            1:       return 88;
            2:       return 168;
            default: return 224;
        endcase
    endfunction

    always @(negedge sysclk) begin
        logic [18:0] e;
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
        if (wr_en != 4'b0000) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_wr", {13'b0, wr_en, wr_addr, wr_data}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr", {13'b0, wr_en, wr_addr, wr_data}, {13'b0, e});
            end
        end
        if (frame_done) check_eq("done_with_last_wr", exp_q.size(), 0);
    end

    // Invalid cycles carry junk sdin and a spurious frame_sync that must be ignored.
    task automatic send_bit(input logic b, input logic fs, input bit half);
        sdin = b; frame_sync = fs; bit_valid = 1'b1;
        @(posedge sysclk); #1;
        bit_valid = 1'b0; frame_sync = 1'b0;
        if (half) begin
            sdin = ~b; frame_sync = 1'b1;
            @(posedge sysclk); #1;
            frame_sync = 1'b0;
        end
    endtask

    task automatic send_byte(input int k, input bit fs_first, input bit half, input bit push, input int nbits);
        logic [7:0] d;
        int s;
        d = k[7:0];
        s = seg_of(k);
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (i == 0 && push && ch_en[s])
                exp_q.push_back({4'(1 << s), 7'(k - base_of(s)), d});
            send_bit(d[i], fs_first && (i == 7), half);
        end
    endtask

    task automatic send_frame(input bit half);
        for (int k = 0; k < 256; k++) send_byte(k, k == 0, half, 1'b1, 8);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge sysclk); #1; end
    endtask

    task automatic clear_counts();
        wr_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; holder = 1'b1; bit_valid = 1'b0; sdin = 1'b0;
        frame_sync = 1'b0; ch_en = 4'hF;
        idle_cycles(3);
        check_eq("rst_wr_en",   wr_en, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_seg",     seg, 0);
        check_eq("rst_done",    frame_done, 0);
        check_eq("rst_err",     frame_err, 0);
        reset = 1'b0;
        idle_cycles(2);

        // Full frame, all channels, continuous bits
        clear_counts();
        send_frame(1'b0);
        idle_cycles(3);
        check_eq("full_writes", wr_cnt, 256);
        check_eq("full_done",   done_cnt, 1);
        check_eq("full_q",      exp_q.size(), 0);
        check_eq("full_seg",    seg, 0);
        check_eq("full_last_addr", wr_addr, 31);
        check_eq("full_last_data", wr_data, 8'hFF);

        // Channels 0 and 2 only
        clear_counts();
        ch_en = 4'b0101;
        send_frame(1'b0);
        idle_cycles(3);
        check_eq("mask_writes", wr_cnt, 144);
        check_eq("mask_done",   done_cnt, 1);
        check_eq("mask_q",      exp_q.size(), 0);

        // Half-rate bit_valid
        clear_counts();
        ch_en = 4'hF;
        send_frame(1'b1);
        idle_cycles(3);
        check_eq("half_writes", wr_cnt, 256);
        check_eq("half_done",   done_cnt, 1);
        check_eq("half_q",      exp_q.size(), 0);

        // frame_sync at seg1 byte 10 bit 3 restarts the frame
        clear_counts();
        for (int k = 0; k < 98; k++) send_byte(k, k == 0, 1'b0, 1'b1, 8);
        send_byte(98, 1'b0, 1'b0, 1'b0, 4);
        check_eq("err_seg_before", seg, 1);
        send_frame(1'b0);
        idle_cycles(3);
        check_eq("err_pulses", err_cnt, 1);
        check_eq("err_writes", wr_cnt, 98 + 256);
        check_eq("err_done",   done_cnt, 1);
        check_eq("err_q",      exp_q.size(), 0);

        // holder dropped for one cycle mid seg2
        clear_counts();
        for (int k = 0; k < 170; k++) send_byte(k, k == 0, 1'b0, 1'b1, 8);
        send_byte(170, 1'b0, 1'b0, 1'b0, 3);
        check_eq("hold_seg_before", seg, 2);
        holder = 1'b0;
        idle_cycles(1);
        holder = 1'b1;
        check_eq("hold_seg_after", seg, 0);
        for (int k = 0; k < 16; k++) send_byte(k, 1'b0, 1'b0, 1'b0, 8);
        idle_cycles(2);
        check_eq("hold_no_writes", wr_cnt, 170);
        send_frame(1'b0);
        idle_cycles(3);
        check_eq("hold_writes", wr_cnt, 170 + 256);
        check_eq("hold_done",   done_cnt, 1);
        check_eq("hold_q",      exp_q.size(), 0);

        // Asynchronous reset mid-frame
        clear_counts();
        for (int k = 0; k < 6; k++) send_byte(k, k == 0, 1'b0, 1'b1, 8);
        send_byte(6, 1'b0, 1'b0, 1'b0, 3);
        check_eq("arst_addr_before", wr_addr, 5);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_wr_en",   wr_en, 0);
        check_eq("arst_wr_addr", wr_addr, 0);
        check_eq("arst_wr_data", wr_data, 0);
        check_eq("arst_seg",     seg, 0);
        idle_cycles(2);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) send_byte(k, 1'b0, 1'b0, 1'b0, 8);
        idle_cycles(2);
        check_eq("arst_no_writes", wr_cnt, 6);
        check_eq("arst_done",      done_cnt, 0);
        check_eq("final_q",        exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
